// File: rtl/icache_tag_pkg.sv
// Shared constants and types for the instruction-cache tag lookup stage.
package icache_tag_pkg;

    localparam int SETS    = 128;
    localparam int WAYS    = 2;
    localparam int ENTRY_W = 20;
    localparam int TAG_W   = ENTRY_W - 1;
    localparam int IDX_W   = $clog2(SETS);
    localparam int LFSR_W  = 16;

    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    // Tap n of the polynomial sits at state bit n-1.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // One way of the tag SRAM: {valid, tag}.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // A way matches only when it holds a valid copy of the wanted tag.
    function automatic logic entry_match(input entry_t e, input logic [TAG_W-1:0] tag);
        return e.valid && (e.tag == tag);
    endfunction

endpackage

// File: rtl/icache_tag_lookup_if.sv
// Bus bundle for the tag lookup stage: lookup, refill, flush and the SRAM port.
//
// Handshake semantics: a lookup or refill transfers in the cycle where its
// valid and ready are both high; the requester must not assume transfer
// otherwise, and ready may depend combinationally on the same-cycle valids
// and flush_req. resp_valid is a one-cycle strobe with no backpressure.
// flush_req is a single-cycle pulse and needs no ready.
interface icache_tag_lookup_if;
    import icache_tag_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;

    logic               resp_valid;
    logic               resp_hit;
    logic               resp_way;
    logic               resp_victim;
    logic               resp_multihit;

    logic               refill_valid;
    logic               refill_ready;
    logic [IDX_W-1:0]   refill_idx;
    logic               refill_way;
    logic [TAG_W-1:0]   refill_tag;

    logic               flush_req;
    logic               busy;
    state_t             dbg_state;

    logic               arr_en;
    logic               arr_wmode;
    logic [IDX_W-1:0]   arr_addr;
    logic [ENTRY_W-1:0] arr_wdata0;
    logic [ENTRY_W-1:0] arr_wdata1;
    logic [WAYS-1:0]    arr_wmask;
    logic [ENTRY_W-1:0] arr_rdata0;
    logic [ENTRY_W-1:0] arr_rdata1;

    // Lookup stage side.
    modport slave (
        input  req_valid, req_idx, req_tag,
        output req_ready,
        output resp_valid, resp_hit, resp_way, resp_victim, resp_multihit,
        input  refill_valid, refill_idx, refill_way, refill_tag,
        output refill_ready,
        input  flush_req,
        output busy, dbg_state,
        output arr_en, arr_wmode, arr_addr, arr_wdata0, arr_wdata1, arr_wmask,
        input  arr_rdata0, arr_rdata1
    );

    // Requester plus SRAM side.
    modport master (
        output req_valid, req_idx, req_tag,
        input  req_ready,
        input  resp_valid, resp_hit, resp_way, resp_victim, resp_multihit,
        output refill_valid, refill_idx, refill_way, refill_tag,
        input  refill_ready,
        output flush_req,
        input  busy, dbg_state,
        input  arr_en, arr_wmode, arr_addr, arr_wdata0, arr_wdata1, arr_wmask,
        output arr_rdata0, arr_rdata1
    );

endinterface

// File: rtl/icache_victim_lfsr.sv
// 16-bit Fibonacci LFSR used to pick a victim way when both ways are valid.
module icache_victim_lfsr
    import icache_tag_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic advance,
    output logic victim_bit
);

    logic [LFSR_W-1:0] lfsr_q;
    logic              feedback;

    assign feedback   = ^(lfsr_q & LFSR_TAPS);
    assign victim_bit = lfsr_q[0];

    // Shift in the feedback bit only when a miss response consumed a victim.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/icache_tag_lookup.sv
// Control stage around the 2-way tag SRAM: arbitrates the invalidate sweep,
// refill writes and lookups onto the single RW port, and turns read data into
// hit / way / victim one cycle after a lookup is accepted.
module icache_tag_lookup
    import icache_tag_pkg::*;
(
    input  logic clock,
    input  logic reset,
    icache_tag_lookup_if.slave bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             pend_q;
    logic [TAG_W-1:0] tag_q;
    logic             lookup_fire;
    entry_t           fill_entry;
    entry_t           rd0, rd1;
    logic             m0, m1, hit;
    logic             lfsr_bit, lfsr_adv;

    assign bus.busy      = (state_q != ST_RUN);
    assign bus.dbg_state = state_q;

    // FSM state and sweep counter; reset always restarts the INIT sweep at set 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, ready signals and the one SRAM operation of this cycle.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        lookup_fire      = 1'b0;
        bus.req_ready    = 1'b0;
        bus.refill_ready = 1'b0;
        bus.arr_en       = 1'b0;
        bus.arr_wmode    = 1'b0;
        bus.arr_addr     = '0;
        bus.arr_wdata0   = '0;
        bus.arr_wdata1   = '0;
        bus.arr_wmask    = '0;
        fill_entry       = '{valid: 1'b1, tag: bus.refill_tag};
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                // Zero both ways of one set per cycle; flush_req is ignored here.
                bus.arr_en    = 1'b1;
                bus.arr_wmode = 1'b1;
                bus.arr_addr  = cnt_q;
                bus.arr_wmask = 2'b11;
                // The counter wraps back to 0 on the last set, ready for the next sweep.
                cnt_d         = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.refill_ready = !bus.flush_req;
                bus.req_ready    = !bus.flush_req && !bus.refill_valid;
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                end else if (bus.refill_valid) begin
                    bus.arr_en     = 1'b1;
                    bus.arr_wmode  = 1'b1;
                    bus.arr_addr   = bus.refill_idx;
                    bus.arr_wdata0 = fill_entry;
                    bus.arr_wdata1 = fill_entry;
                    bus.arr_wmask  = bus.refill_way ? 2'b10 : 2'b01;
                end else if (bus.req_valid) begin
                    bus.arr_en   = 1'b1;
                    bus.arr_addr = bus.req_idx;
                    lookup_fire  = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Remember that a read is in flight and which tag it must be compared with.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            tag_q  <= '0;
        end else begin
            pend_q <= lookup_fire;
            if (lookup_fire) begin
                tag_q <= bus.req_tag;
            end
        end
    end

    assign rd0 = entry_t'(bus.arr_rdata0);
    assign rd1 = entry_t'(bus.arr_rdata1);

    // Compare the SRAM read data as-is; a refill landing now cannot change it.
    always_comb begin
        m0                = entry_match(rd0, tag_q);
        m1                = entry_match(rd1, tag_q);
        hit               = m0 | m1;
        bus.resp_valid    = pend_q;
        bus.resp_hit      = pend_q & hit;
        bus.resp_way      = pend_q & m1 & ~m0;
        bus.resp_multihit = pend_q & m0 & m1;
        bus.resp_victim   = 1'b0;
        if (pend_q) begin
            if (!rd0.valid) begin
                bus.resp_victim = 1'b0;
            end else if (!rd1.valid) begin
                bus.resp_victim = 1'b1;
            end else begin
                bus.resp_victim = lfsr_bit;
            end
        end
        lfsr_adv = pend_q & ~hit;
    end

    icache_victim_lfsr u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .advance    (lfsr_adv),
        .victim_bit (lfsr_bit)
    );

endmodule

// File: tb/tb_icache_tag_lookup.sv
// Bench for icache_tag_lookup: drives lookups/refills/flushes, models the tag
// SRAM, and checks responses through an expected queue.
module tb_icache_tag_lookup;
    import icache_tag_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    icache_tag_lookup_if bus ();

    icache_tag_lookup dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- SRAM model ----------------
    logic [ENTRY_W-1:0] mem0 [SETS];
    logic [ENTRY_W-1:0] mem1 [SETS];

    always @(posedge clock) begin
        if (bus.arr_en) begin
            if (bus.arr_wmode) begin
                if (bus.arr_wmask[0]) mem0[bus.arr_addr] <= bus.arr_wdata0;
                if (bus.arr_wmask[1]) mem1[bus.arr_addr] <= bus.arr_wdata1;
            end else begin
                bus.arr_rdata0 <= mem0[bus.arr_addr];
                bus.arr_rdata1 <= mem1[bus.arr_addr];
            end
        end
    end

    // ---------------- reference model ----------------
    bit          ref_v [2][SETS];
    logic [18:0] ref_t [2][SETS];
    logic [15:0] ref_lfsr;
    bit          run;
    int          sweep_left;

    // {due cycle[15:0], hit, way, victim, multihit}
    logic [19:0] exp_q[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        // x^16 + x^14 + x^13 + x^11 + 1, new bit enters at bit 0
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < SETS; s++) begin
                ref_v[w][s] = 1'b0;
                ref_t[w][s] = '0;
            end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        model_clear();
        ref_lfsr   = 16'h0001;
        run        = 1'b0;
        sweep_left = SETS;
        #2;
        check("rst_busy", bus.busy, 1);
        check("rst_state", bus.dbg_state, ST_INIT);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_hit", {bus.resp_hit, bus.resp_way, bus.resp_victim, bus.resp_multihit}, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_addr", bus.arr_addr, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One clock cycle of stimulus with all expectations for that cycle.
    task automatic cycle(input bit fl, input bit fv, input int fidx, input bit fway,
                         input logic [18:0] ftag, input bit qv, input int qidx,
                         input logic [18:0] qtag);
        bit m0, m1, h, way, vic;
        bus.flush_req    = fl;
        bus.refill_valid = fv;
        bus.refill_idx   = 7'(fidx);
        bus.refill_way   = fway;
        bus.refill_tag   = ftag;
        bus.req_valid    = qv;
        bus.req_idx      = 7'(qidx);
        bus.req_tag      = qtag;
        @(negedge clock);
        check("busy", bus.busy, !run);
        check("refill_ready", bus.refill_ready, run && !fl);
        check("req_ready", bus.req_ready, run && !fl && !fv);
        if (!run) begin
            check("sweep_en", {bus.arr_en, bus.arr_wmode, bus.arr_wmask}, 4'b1111);
            check("sweep_addr", bus.arr_addr, SETS - sweep_left);
            check("sweep_wdata", {bus.arr_wdata1, bus.arr_wdata0}, 0);
            sweep_left--;
            if (sweep_left == 0) run = 1'b1;
        end else if (fl) begin
            check("flush_idle", {bus.arr_en, bus.arr_wmask}, 0);
            model_clear();
            run        = 1'b0;
            sweep_left = SETS;
        end else if (fv) begin
            check("refill_en", {bus.arr_en, bus.arr_wmode}, 2'b11);
            check("refill_addr", bus.arr_addr, fidx);
            check("refill_mask", bus.arr_wmask, fway ? 2 : 1);
            check("refill_wdata0", bus.arr_wdata0, {1'b1, ftag});
            check("refill_wdata1", bus.arr_wdata1, {1'b1, ftag});
            ref_v[fway][fidx] = 1'b1;
            ref_t[fway][fidx] = ftag;
        end else if (qv) begin
            check("lookup_en", {bus.arr_en, bus.arr_wmode, bus.arr_wmask}, 4'b1000);
            check("lookup_addr", bus.arr_addr, qidx);
            m0  = ref_v[0][qidx] && ref_t[0][qidx] == qtag;
            m1  = ref_v[1][qidx] && ref_t[1][qidx] == qtag;
            h   = m0 || m1;
            way = (m1 && !m0);
            if (!ref_v[0][qidx])      vic = 1'b0;
            else if (!ref_v[1][qidx]) vic = 1'b1;
            else                      vic = ref_lfsr[0];
            if (!h) ref_lfsr = lfsr_next(ref_lfsr);
            exp_q.push_back({16'(cyc + 1), h, way, vic, m0 && m1});
        end else begin
            check("idle", {bus.arr_en, bus.arr_wmask}, 0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic refill(input int idx, input bit way, input logic [18:0] tag);
        cycle(0, 1, idx, way, tag, 0, 0, 0);
    endtask

    task automatic lookup(input int idx, input logic [18:0] tag);
        cycle(0, 0, 0, 0, 0, 1, idx, tag);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [19:0] e;
        if (!reset) begin
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual=1 expected=0 cycle=%0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_cycle", 32'(cyc[15:0]), 32'(e[19:4]));
                    check("resp_hit", bus.resp_hit, e[3]);
                    check("resp_way", bus.resp_way, e[2]);
                    check("resp_victim", bus.resp_victim, e[1]);
                    check("resp_multihit", bus.resp_multihit, e[0]);
                end
            end else if (exp_q.size() != 0 && exp_q[0][19:4] < cyc[15:0]) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL resp_missing actual=0 expected=1 cycle=%0d", cyc);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.req_valid    = 0;
        bus.req_idx      = 0;
        bus.req_tag      = 0;
        bus.refill_valid = 0;
        bus.refill_idx   = 0;
        bus.refill_way   = 0;
        bus.refill_tag   = 0;
        bus.flush_req    = 0;
        bus.arr_rdata0   = 0;
        bus.arr_rdata1   = 0;
        for (int s = 0; s < SETS; s++) begin
            mem0[s] = 20'($urandom);
            mem1[s] = 20'($urandom);
        end
        #1;
        do_reset();
        // Reset in the middle of the INIT sweep restarts it from set 0.
        idle(60);
        do_reset();
        idle(SETS);

        // Both ways valid on set 9: misses pick victims from the LFSR.
        refill(9, 0, 19'h00001);
        refill(9, 1, 19'h00002);
        lookup(9, 19'h00003);
        lookup(9, 19'h00003);
        lookup(9, 19'h00003);
        idle(2);

        // Refill way 1 then hit on it; a different tag misses with victim 0.
        refill(5, 1, 19'h1ABCD);
        lookup(5, 19'h1ABCD);
        lookup(5, 19'h1ABCE);
        idle(1);

        // Refill wins over a same-cycle lookup; the lookup goes next cycle.
        cycle(0, 1, 7, 0, 19'h00055, 1, 7, 19'h00055);
        lookup(7, 19'h00055);
        idle(1);

        // Same tag in both ways: multihit reports way 0.
        refill(3, 0, 19'h00077);
        refill(3, 1, 19'h00077);
        lookup(3, 19'h00077);
        idle(1);

        // Flush right behind a hit: the response still arrives, then a full sweep.
        lookup(5, 19'h1ABCD);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < SETS; i++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 127),
                  1'($urandom_range(0, 1)), 19'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 127), 19'($urandom));
        lookup(5, 19'h1ABCD);
        idle(2);

        // Random mix over a few sets and tags to provoke hits, misses and multihits.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7), 1'($urandom_range(0, 1)), 19'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7), 19'($urandom_range(0, 3)));
        idle(3);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
